// File: rtl/path_delay_meter_pkg.sv
// Shared definitions for the path delay meter: FSM state encoding and synchronizer depth.
// SYNC_STAGES also feeds the host-side correction of the fixed offset in every delay.
package path_delay_meter_pkg;

    localparam int SYNC_STAGES = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_LAUNCH = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_RECORD = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

endpackage

// File: rtl/path_delay_meter_sync_2ff.sv
// Multi-flop synchronizer for a single asynchronous level, reset to 0.
// Depth comes from the shared package so capture blocks agree on the offset.
module sync_2ff
    import path_delay_meter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stage;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage <= '0;
        end else begin
            stage <= {stage[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/path_delay_meter.sv
// Launch/capture controller: toggles a delay chain input, times how long the chain output
// takes to follow over 2^LOG_TRIALS alternating-edge trials, and reports avg/min/max.
module path_delay_meter
    import path_delay_meter_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int LOG_TRIALS     = 4,
    parameter int SETTLE_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             pathInput,
    input  logic             pathResult,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] delayAvg,
    output logic [CNT_W-1:0] delayMin,
    output logic [CNT_W-1:0] delayMax
);

    localparam int SUM_W = CNT_W + LOG_TRIALS;
    // The LAUNCH cycle is the last cycle the old level is held, so SETTLE itself
    // covers one cycle fewer than SETTLE_CYCLES.
    localparam logic [CNT_W-1:0]      SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 2);
    localparam logic [CNT_W-1:0]      TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LOG_TRIALS-1:0] LAST_TRIAL   = '1;

    logic [2:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      lastDelay;
    logic [LOG_TRIALS-1:0] trial;
    logic [SUM_W-1:0]      sum;
    logic [CNT_W-1:0]      minDelay;
    logic [CNT_W-1:0]      maxDelay;
    logic                  resultSync;

    logic [SUM_W-1:0]      sumNext;
    logic [CNT_W-1:0]      minNext;
    logic [CNT_W-1:0]      maxNext;

    sync_2ff uSync (
        .clk (clk),
        .rst (rst),
        .d   (pathResult),
        .q   (resultSync)
    );

    // Statistics including the trial being recorded, so the last trial can load the outputs directly.
    always_comb begin
        sumNext = sum + SUM_W'(lastDelay);
        minNext = (lastDelay < minDelay) ? lastDelay : minDelay;
        maxNext = (lastDelay > maxDelay) ? lastDelay : maxDelay;
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            lastDelay <= '0;
            trial     <= '0;
            sum       <= '0;
            minDelay  <= '0;
            maxDelay  <= '0;
            pathInput <= 1'b0;
            timeout   <= 1'b0;
            delayAvg  <= '0;
            delayMin  <= '0;
            delayMax  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_SETTLE;
                        sum      <= '0;
                        minDelay <= '1;
                        maxDelay <= '0;
                        trial    <= '0;
                        timeout  <= 1'b0;
                        cnt      <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt <= '0;
                        if (resultSync == pathInput) begin
                            state <= ST_LAUNCH;
                        end else begin
                            timeout <= 1'b1;
                            state   <= ST_DONE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    pathInput <= ~pathInput;
                    cnt       <= '0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (resultSync == pathInput) begin
                        lastDelay <= cnt;
                        state     <= ST_RECORD;
                    end else if (cnt == TIMEOUT_LAST) begin
                        timeout <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RECORD: begin
                    sum      <= sumNext;
                    minDelay <= minNext;
                    maxDelay <= maxNext;
                    trial    <= trial + 1'b1;
                    cnt      <= '0;
                    if (trial == LAST_TRIAL) begin
                        delayAvg <= sumNext[SUM_W-1:LOG_TRIALS];
                        delayMin <= minNext;
                        delayMax <= maxNext;
                        state    <= ST_DONE;
                    end else begin
                        state <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_path_delay_meter.sv
// Scoreboard bench for path_delay_meter: expected results are queued at each start
// and checked when done pulses.
module tb_path_delay_meter;

    localparam int CNT_W   = 16;
    localparam int SETTLE  = 64;
    localparam int TMO     = 4096;
    localparam int TRIALS  = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             pathInput;
    logic             pathResult;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] delayAvg;
    logic [CNT_W-1:0] delayMin;
    logic [CNT_W-1:0] delayMax;

    typedef struct {
        int avg;
        int mn;
        int mx;
        int to;
        int lat;
        int startCyc;
    } expect_t;

    expect_t sb[$];

    int nCompared   = 0;
    int nMismatched = 0;
    int cyc         = 0;
    int doneCount   = 0;
    int mode        = 0;
    logic [31:0] hist = '0;

    path_delay_meter #(
        .CNT_W          (CNT_W),
        .LOG_TRIALS     (4),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pathInput  (pathInput),
        .pathResult (pathResult),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .delayAvg   (delayAvg),
        .delayMin   (delayMin),
        .delayMax   (delayMax)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        hist <= {hist[30:0], pathInput};
    end

    // Chain models: 0 = zero lag, 1 = 10 cycles rising / 14 falling, 2 = stuck 0, 3 = stuck 1
    assign pathResult = (mode == 0) ? pathInput :
                        (mode == 1) ? (hist[9] | hist[13]) :
                        (mode == 2) ? 1'b0 : 1'b1;

    task automatic checkEq(input string tag, input int obs, input int exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Cycles for one trial whose chain lags by d cycles: settle + launch + wait + record.
    function automatic int trialCycles(input int d);
        return (SETTLE - 1) + 1 + (d + 2 + 1) + 1;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            expect_t e;
            doneCount++;
            if (sb.size() == 0) begin
                checkEq("spurious_done", done, 0);
            end else begin
                e = sb.pop_front();
                $display("done: avg=%0d min=%0d max=%0d timeout=%0d latency=%0d",
                         delayAvg, delayMin, delayMax, timeout, cyc - e.startCyc);
                checkEq("avg", delayAvg, e.avg);
                checkEq("min", delayMin, e.mn);
                checkEq("max", delayMax, e.mx);
                checkEq("timeout", timeout, e.to);
                checkEq("latency", cyc - e.startCyc, e.lat);
            end
        end
    end

    task automatic startMeas(input int avg, input int mn, input int mx, input int to, input int lat);
        expect_t e;
        @(negedge clk);
        start = 1'b1;
        e.avg = avg; e.mn = mn; e.mx = mx; e.to = to; e.lat = lat; e.startCyc = cyc;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDrained(input string tag, input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        checkEq(tag, sb.size(), 0);
    endtask

    task automatic checkResetState(input string tag);
        checkEq({tag, "_pathInput"}, pathInput, 0);
        checkEq({tag, "_busy"}, busy, 0);
        checkEq({tag, "_done"}, done, 0);
        checkEq({tag, "_timeout"}, timeout, 0);
        checkEq({tag, "_avg"}, delayAvg, 0);
        checkEq({tag, "_min"}, delayMin, 0);
        checkEq({tag, "_max"}, delayMax, 0);
    endtask

    initial begin
        int lat1;
        int lat2;
        int dcBefore;
        bit sawDone;
        lat1 = TRIALS * trialCycles(0) + 1;
        lat2 = (TRIALS / 2) * trialCycles(10) + (TRIALS / 2) * trialCycles(14) + 1;

        // Reset state
        repeat (3) @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Zero-lag chain
        mode = 0;
        startMeas(2, 2, 2, 0, lat1);
        waitDrained("wait_zero_lag", lat1 + 50);

        // Asymmetric rising/falling delay
        mode = 1;
        repeat (40) @(negedge clk);
        startMeas(14, 12, 16, 0, lat2);
        waitDrained("wait_asym", lat2 + 50);

        // Stuck-0 chain: first WAIT times out, outputs hold previous results
        mode = 2;
        startMeas(14, 12, 16, 1, (SETTLE - 1) + 1 + TMO + 1);
        waitDrained("wait_stuck0", TMO + 200);

        // Stuck-1 chain from reset: settle check fails, no launch
        mode = 3;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        startMeas(0, 0, 0, 1, SETTLE);
        waitDrained("wait_stuck1", SETTLE + 50);
        checkEq("stuck1_no_launch", pathInput, 0);

        // Reset during WAIT of the fifth trial
        mode = 0;
        repeat (4) @(negedge clk);
        startMeas(2, 2, 2, 0, lat1);
        waitDrained("wait_pre_reset", lat1 + 50);
        dcBefore = doneCount;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4 * trialCycles(0) + (SETTLE - 1) + 1 + 2 - 1) @(negedge clk);
        checkEq("wait_level_before_rst", pathInput, 1);
        checkEq("busy_before_rst", busy, 1);
        rst = 1'b1;
        #1;
        checkResetState("midrun_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checkEq("rst_no_done", doneCount - dcBefore, 0);
        startMeas(2, 2, 2, 0, lat1);
        waitDrained("wait_post_reset", lat1 + 50);

        // start while busy and during the DONE cycle is ignored
        dcBefore = doneCount;
        startMeas(2, 2, 2, 0, lat1);
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sawDone = 1'b0;
        for (int i = 0; i < lat1 + 50 && !sawDone; i++) begin
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        checkEq("done_seen", sawDone, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkEq("busy_after_done_start", busy, 0);
        repeat (lat1 + 100) @(negedge clk);
        checkEq("single_done", doneCount - dcBefore, 1);
        checkEq("queue_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
